// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch PC, imem request/response tracking and decode buffer.
// Optional macro IF_BYPASS_EN forwards a response straight to decode when the buffer is empty.
module instr_fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [63:0] id_pc,
    input  logic        id_ready,
    output logic [63:0] fetch_pc
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

    typedef enum logic {RUN, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [63:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d, count_q, count_d, drop_q, drop_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [31:0]   instr_mem [FIFO_DEPTH];
    logic [63:0]   pc_mem [FIFO_DEPTH];
    logic [63:0]   redirect_tgt;
    logic [CW:0]   credits_used;
    logic          req_fire, rsp_keep, push, pop, bypass, not_empty;

    assign redirect_tgt   = redirect_pc & ~64'h3;
    assign credits_used   = {1'b0, inflight_q} + {1'b0, count_q};
    // Gated by rst so no request can leak out while memory is also held in reset.
    assign imem_req_valid = rst && !redirect_valid && credits_used < DEPTH_C;
    assign imem_req_addr  = fetch_pc_q;
    assign fetch_pc       = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && state_q == RUN && !redirect_valid;
    assign not_empty      = count_q != '0;
`ifdef IF_BYPASS_EN
    assign bypass   = rsp_keep && !not_empty;
    assign id_valid = not_empty || bypass;
    assign id_instr = not_empty ? instr_mem[rd_ptr_q] : bypass ? imem_rsp_data : '0;
    assign id_pc    = not_empty ? pc_mem[rd_ptr_q] : bypass ? rsp_pc_q : RESET_PC;
`else
    assign bypass   = 1'b0;
    assign id_valid = not_empty;
    assign id_instr = not_empty ? instr_mem[rd_ptr_q] : '0;
    assign id_pc    = not_empty ? pc_mem[rd_ptr_q] : RESET_PC;
`endif
    assign push = rsp_keep && !(bypass && id_ready);
    assign pop  = not_empty && id_ready;

    always_comb begin
        fetch_pc_d = req_fire ? fetch_pc_q + 64'd4 : fetch_pc_q;
        rsp_pc_d   = rsp_keep ? rsp_pc_q + 64'd4 : rsp_pc_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
        count_d    = count_q + CW'(push) - CW'(pop);
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        drop_d     = (state_q == DRAIN && imem_rsp_valid) ? drop_q - CW'(1) : drop_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_tgt;
            rsp_pc_d   = redirect_tgt;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            drop_d     = inflight_q - CW'(imem_rsp_valid);
        end
        state_d = drop_d == '0 ? RUN : DRAIN;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            count_q    <= '0;
            drop_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= imem_rsp_data;
            pc_mem[wr_ptr_q]    <= rsp_pc_q;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed bench for instr_fetch_unit with a fixed-latency in-order memory model.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [63:0] id_pc;
    logic        id_ready;
    logic [63:0] fetch_pc;

    int vec = 0;
    int errs = 0;
    int lat = 1;
    int n_fire;
    int ecount;
    logic [63:0] exp_addr;

    typedef struct {
        logic [63:0] a;
        int          due;
    } req_t;
    req_t        mq[$];
    logic [63:0] dlog[$];

    instr_fetch_unit #(.RESET_PC(64'h0), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready),
        .fetch_pc(fetch_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input logic [63:0] a);
        return a[31:0] + 32'h1000_0000;
    endfunction

    // Memory answers in order, lat cycles after the handshake; decode deliveries are logged.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            dlog.delete();
            n_fire = 0;
            ecount = 0;
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
        end else begin
            if (id_valid && id_ready) dlog.push_back(id_pc);
            if (imem_req_valid && imem_req_ready) begin
                mq.push_back('{imem_req_addr, ecount + lat - 1});
                n_fire++;
            end
            if (mq.size() > 0 && mq[0].due <= ecount) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= dat(mq[0].a);
                void'(mq.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
            end
            ecount++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start(input int l, input logic rdy);
        @(negedge clk);
        rst = 1'b0;
        lat = l;
        id_ready = rdy;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        imem_req_ready = 1'b1;
        id_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        step();
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_id_valid", id_valid, 0);
        chk("rst_id_instr", id_instr, 0);
        chk("rst_id_pc", id_pc, 0);
        chk("rst_fetch_pc", fetch_pc, 0);

        // streaming at latency 1
        start(1, 1'b1);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) step();
            chk("stream_req_valid", imem_req_valid, 1);
            chk("stream_addr", imem_req_addr, 64'(4 * k));
            if (k >= 2) begin
                chk("stream_id_valid", id_valid, 1);
                chk("stream_id_pc", id_pc, 64'(4 * (k - 2)));
                chk("stream_id_instr", id_instr, 64'(32'h1000_0000 + 32'(4 * (k - 2))));
            end else begin
                chk("stream_id_idle", id_valid, 0);
            end
        end

        // credits run out with decode stalled
        start(1, 1'b0);
        chk("cred_addr0", imem_req_addr, 64'h0);
        step(); chk("cred_addr1", imem_req_addr, 64'h4);
        step(); chk("cred_addr2", imem_req_addr, 64'h8);
        step(); chk("cred_addr3", imem_req_addr, 64'hC);
        step(); chk("cred_full_valid", imem_req_valid, 0);
        chk("cred_fetch_pc", fetch_pc, 64'h10);
        step();
        chk("cred_full_valid2", imem_req_valid, 0);
        chk("cred_head_pc", id_pc, 64'h0);
        chk("cred_fires", 64'(n_fire), 4);
        @(negedge clk); id_ready = 1'b1; #1;
        chk("cred_pop_valid", imem_req_valid, 0);
        @(negedge clk); id_ready = 1'b0; #1;
        chk("cred_regain_valid", imem_req_valid, 1);
        chk("cred_regain_addr", imem_req_addr, 64'h10);
        chk("cred_next_head", id_pc, 64'h4);
        step();
        chk("cred_refull_valid", imem_req_valid, 0);
        chk("cred_fires2", 64'(n_fire), 5);

        // redirect with three requests in flight at latency 5
        start(5, 1'b1);
        step(); step();
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 64'h1003; #1;
        chk("redir_req_blocked", imem_req_valid, 0);
        @(negedge clk); redirect_valid = 1'b0; #1;
        chk("redir_req_valid", imem_req_valid, 1);
        chk("redir_addr", imem_req_addr, 64'h1000);
        chk("redir_fetch_pc", fetch_pc, 64'h1000);
        chk("redir_id_idle", id_valid, 0);
        for (int k = 5; k < 10; k++) begin
            step();
            chk("redir_drain_idle", id_valid, 0);
        end
        step();
        chk("redir_id_valid", id_valid, 1);
        chk("redir_id_pc", id_pc, 64'h1000);
        chk("redir_id_instr", id_instr, 64'h1000_1000);
        chk("redir_none_delivered", 64'(dlog.size()), 0);

        // redirect coinciding with a response and a decode pop
        start(2, 1'b1);
        repeat (4) step();
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 64'h2000; #1;
        chk("coll_id_valid", id_valid, 1);
        chk("coll_id_pc", id_pc, 64'h8);
        chk("coll_req_blocked", imem_req_valid, 0);
        @(negedge clk); redirect_valid = 1'b0; #1;
        chk("coll_flushed", id_valid, 0);
        chk("coll_addr", imem_req_addr, 64'h2000);
        step(); chk("coll_drop_idle", id_valid, 0);
        step(); chk("coll_wait_idle", id_valid, 0);
        step();
        chk("coll_new_valid", id_valid, 1);
        chk("coll_new_pc", id_pc, 64'h2000);
        chk("coll_new_instr", id_instr, 64'h1000_2000);
        step();
        chk("coll_log_n", 64'(dlog.size()), 4);
        chk("coll_log2", dlog[2], 64'h8);
        chk("coll_log3", dlog[3], 64'h2000);

        // ready toggling and address wrap
        start(1, 1'b1);
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFA; #1;
        chk("wrap_redir_blocked", imem_req_valid, 0);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            redirect_valid = 1'b0;
            imem_req_ready = (k < 24) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            exp_addr = 64'hFFFF_FFFF_FFFF_FFF8 + 64'(4 * n_fire);
            chk("wrap_req_valid", imem_req_valid, 1);
            chk("wrap_addr", imem_req_addr, exp_addr);
        end
        step();
        chk("wrap_log_enough", 64'(dlog.size() >= 3), 1);
        chk("wrap_log0", dlog[0], 64'hFFFF_FFFF_FFFF_FFF8);
        chk("wrap_log1", dlog[1], 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_log2", dlog[2], 64'h0);

        // reset mid-operation: two in flight, buffer half full
        start(3, 1'b0);
        repeat (5) step();
        chk("mid_req_blocked", imem_req_valid, 0);
        chk("mid_id_valid", id_valid, 1);
        chk("mid_id_pc", id_pc, 64'h0);
        rst = 1'b0; #1;
        chk("mid_rst_req_valid", imem_req_valid, 0);
        chk("mid_rst_id_valid", id_valid, 0);
        chk("mid_rst_id_instr", id_instr, 0);
        chk("mid_rst_id_pc", id_pc, 0);
        chk("mid_rst_fetch_pc", fetch_pc, 0);
        @(negedge clk); rst = 1'b1; lat = 1; id_ready = 1'b1; #1;
        chk("post_rst_req_valid", imem_req_valid, 1);
        chk("post_rst_addr", imem_req_addr, 64'h0);
        chk("post_rst_id_idle", id_valid, 0);
        step(); chk("post_rst_id_idle2", id_valid, 0);
        step();
        chk("post_rst_id_valid", id_valid, 1);
        chk("post_rst_id_pc", id_pc, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage that feeds the decode stage of Olivia. It owns the fetch program counter, issues word requests to instruction memory over a valid/ready request channel, and buffers in-order responses in a small FIFO. The decode stage receives instructions and their PCs over a valid/ready handshake. Redirects from later stages (branches, jumps) flush the buffer and discard stale in-flight responses.

## Interface
- `RESET_PC`, 64'h0: fetch address after reset; bits [1:0] must be 0.
- `FIFO_DEPTH`, 4: instruction buffer entries and maximum credits; power of two, ≥2.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: asynchronous reset, active-low.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_addr` out 64: word address of the request; always equals `fetch_pc`.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_rsp_valid` in 1: response valid; responses return in request order, one per cycle maximum, and are always accepted.
- `imem_rsp_data` in 32: instruction word.
- `redirect_valid` in 1: one-cycle redirect pulse.
- `redirect_pc` in 64: new fetch target; bits [1:0] are ignored and treated as 0.
- `id_valid` out 1: instruction available to decode.
- `id_instr` out 32: instruction word.
- `id_pc` out 64: PC of `id_instr`.
- `id_ready` in 1: decode consumes the instruction this cycle.
- `fetch_pc` out 64: next address to request.

## Operation
- Counters: `inflight`, the number of accepted requests without a response (0..FIFO_DEPTH); `fifo_count` (0..FIFO_DEPTH); `drop_cnt`, the number of stale responses still to discard.
- Request rule: `imem_req_valid = !redirect_valid && (inflight + fifo_count < FIFO_DEPTH)`. A request handshake increments `inflight` and sets `fetch_pc += 4`, which wraps modulo 2^64.
- Once asserted, a request is held with a stable address until accepted. It may be withdrawn only in a redirect cycle.
- The `rsp_pc` register tracks the PC of the next kept response. A kept response writes {data, `rsp_pc`} to the FIFO and sets `rsp_pc += 4`. Every response decrements `inflight`.
- States:
  - RUN: `drop_cnt == 0`. Responses are kept.
  - DRAIN: `drop_cnt > 0`. Each response is discarded and decrements `drop_cnt`. The block returns to RUN when `drop_cnt` reaches 0.
  - New requests may issue during DRAIN. In-order return guarantees that drops precede new data.
- Redirect cycle:
  - The FIFO is flushed.
  - Both `fetch_pc` and `rsp_pc` are set to `{redirect_pc[63:2],2'b00}`.
  - `drop_cnt` is set to `inflight` minus any response arriving this cycle. A response arriving this cycle is discarded.
  - The state becomes DRAIN if the new `drop_cnt > 0`, otherwise RUN.
  - A redirect during DRAIN reloads `drop_cnt` by the same rule.
- Decode handshake: `id_valid` is asserted when the FIFO is non-empty. An `id_valid && id_ready` handshake pops the head entry.
  - If a pop and a redirect occur in the same cycle, the flush wins. The popped instruction still counts as delivered.
- Credits: the request rule guarantees the FIFO never overflows. A simultaneous push and pop in the same cycle leaves `fifo_count` unchanged.
- Reset values: `fetch_pc` and `rsp_pc` = RESET_PC; `inflight`, `fifo_count`, `drop_cnt` = 0; state RUN; `id_valid` = 0; `id_instr` = 0; `id_pc` = RESET_PC.
  - `imem_req_valid` is 0 while `rst` is low.
  - Asserting reset mid-operation abandons all in-flight requests. Instruction memory must be reset together with this block.

## Timing
- The first request is presented in the first cycle after `rst` deasserts, with `imem_req_addr` = RESET_PC.
- Request throughput is one per cycle while credits remain.
- With memory latency L from request handshake to response, `id_valid` rises L+1 cycles after the handshake. This is 0 extra cycles with bypass (see Configuration).
- After a redirect, the first request to the new target is presented in the next cycle.

## Configuration
- `IF_BYPASS_EN` defined:
  - When the FIFO is empty, a response is kept, and there is no redirect, that response drives `id_valid`, `id_instr`, and `id_pc` combinationally in the same cycle.
  - If `id_ready` is high that cycle, the response is not written to the FIFO.
- `IF_BYPASS_EN` undefined: all instructions pass through the FIFO, adding one cycle of latency. There is no combinational path from `imem_rsp_*` to `id_*`.

## Test plan
- Reset deasserts, `imem_req_ready`=1, memory latency 1, `id_ready`=1 → requests at 0x0, 0x4, 0x8… on consecutive cycles; `id_pc` sequence 0x0, 0x4, 0x8 with matching data; no gaps after the pipeline fills.
- `id_ready`=0, memory always ready, FIFO_DEPTH=4 → exactly 4 requests accepted, then `imem_req_valid`=0; raise `id_ready` → one new request per pop.
- 3 requests in flight, latency 5, `redirect_valid` with `redirect_pc`=0x1003 → FIFO empties; the next 3 responses are discarded; the first delivered `id_pc`=0x1000.
- Redirect in the same cycle as a response and a decode pop → that response is dropped; `drop_cnt` = remaining in-flight count; no stale instruction reaches decode.
- `imem_req_ready` toggling randomly → address held stable while not ready; `fetch_pc` near 2^64−4 wraps to 0x0.
- `rst` pulled low with 2 requests in flight and FIFO half full → all outputs return to reset values immediately; after release, the first request is at RESET_PC.
